// File: rtl/rotation_split_ctrl.sv
// Sequencer that slices keypoint cos/sin vectors into NUM_SLICES 128-entry
// slices for the rotation datapath: latch, present each slice, pulse done.
module rotation_split_ctrl #(
  parameter int NUM_SLICES = 4,
  parameter int IDX_BW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              slice_ready,
  output logic              latch_ena,
  output logic              compute,
  output logic              slice_valid,
  output logic [IDX_BW-1:0] slice_idx,
  output logic              last_slice,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_SLICES - 1);

  state_t            state_q, state_d;
  logic [IDX_BW-1:0] cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic              at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign at_last = (cnt_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    latch_ena   = 1'b0;
    compute     = 1'b0;
    slice_valid = 1'b0;
    slice_idx   = '0;
    last_slice  = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;

    // Any start seen while a keypoint is in flight (DONE included) is sticky.
    if (start && busy) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) state_d = LATCH;
      end
      LATCH: begin
        latch_ena = 1'b1;
        cnt_d     = '0;
        state_d   = VALID;
      end
      VALID: begin
        slice_valid = 1'b1;
        slice_idx   = cnt_q;
        last_slice  = at_last;
        if (slice_ready) begin
          if (at_last) begin
            state_d = DONE;
          end else begin
            compute = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything and squelches the strobes of this cycle.
    if (abort && busy) begin
      state_d   = IDLE;
      cnt_d     = '0;
      latch_ena = 1'b0;
      compute   = 1'b0;
      done      = 1'b0;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: doc/rotation_split_ctrl.md
ROTATION_SPLIT_CTRL -- requirements
Module: rotation_split_ctrl

Interface
REQ-001 Parameter NUM_SLICES, default 4, number of 128-entry slices per keypoint trigonometry vector (legal range 2..16).
REQ-002 Parameter IDX_BW, default 2, width of slice_idx; SHALL satisfy 2**IDX_BW >= NUM_SLICES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  new in_cos/in_sin vectors valid upstream; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of the current keypoint.
REQ-007 slice_ready  input  1  downstream rotation datapath accepts the current slice.
REQ-008 latch_ena  output  1  load strobe to the vector-split register.
REQ-009 compute  output  1  shift strobe to the vector-split register.
REQ-010 slice_valid  output  1  current 128-entry slice on the split outputs is valid.
REQ-011 slice_idx  output  IDX_BW  index of the slice currently presented (0 first).
REQ-012 last_slice  output  1  high while slice_valid and slice_idx == NUM_SLICES-1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last slice is accepted.
REQ-015 overrun  output  1  sticky: start asserted while busy.

Function
REQ-016 FSM states SHALL be IDLE, LATCH, VALID, DONE, state held in registers.
REQ-017 IDLE: start=1 and abort=0 SHALL move to LATCH next cycle; otherwise remain in IDLE.
REQ-018 LATCH: latch_ena SHALL be 1 for exactly this one cycle; slice counter cleared to 0; next state VALID unconditionally (unless abort).
REQ-019 VALID: slice_valid=1, slice_idx=counter; state held until slice_ready=1.
REQ-020 In VALID with slice_ready=1 and counter < NUM_SLICES-1: compute SHALL be 1 in that same cycle (combinational from state, counter, slice_ready), counter increments, state stays VALID.
REQ-021 In VALID with slice_ready=1 and counter == NUM_SLICES-1: compute SHALL be 0, next state DONE.
REQ-022 DONE: done=1 for exactly one cycle, next state IDLE, counter cleared.
REQ-023 latch_ena and compute SHALL never be 1 in the same cycle; compute SHALL be 0 outside VALID.
REQ-024 Latency: start sampled in cycle N -> latch_ena in N+1 -> slice_valid with slice_idx=0 in N+2; with slice_ready held 1, done in N+2+NUM_SLICES.
REQ-025 Total compute pulses per completed keypoint SHALL equal NUM_SLICES-1.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE next cycle, clear counter, and suppress compute, latch_ena and done in the abort cycle; abort has priority over slice_ready and start.
REQ-027 start=1 while busy SHALL be ignored for sequencing and SHALL set overrun to 1 next cycle; overrun clears only on rst.
REQ-028 start=1 in DONE SHALL count as overrun (DONE is busy); start in the cycle after DONE is accepted normally.
REQ-029 slice_ready when slice_valid=0 SHALL have no effect.
REQ-030 Counter SHALL never exceed NUM_SLICES-1 (no wrap-around).

Reset
REQ-031 rst=1 SHALL immediately, without clock, force state IDLE, counter 0, overrun 0.
REQ-032 During and after reset until start: latch_ena=0, compute=0, slice_valid=0, slice_idx=0, last_slice=0, busy=0, done=0.
REQ-033 rst asserted mid-sequence SHALL abandon the keypoint; no done pulse issued.

Verification
REQ-034 NUM_SLICES=4, start pulse cycle 0, slice_ready held 1 -> latch_ena cycle 1; slice_valid cycles 2-5 with slice_idx 0,1,2,3; compute cycles 2,3,4; last_slice cycle 5; done cycle 6; busy cycles 1-6.
REQ-035 slice_ready low for 3 cycles on slice_idx=1 -> slice_idx stays 1, compute 0 during stall, exactly 3 compute pulses total, done delayed 3 cycles.
REQ-036 abort at slice_idx=2 with slice_ready=1 -> no compute that cycle, IDLE next cycle, done never pulses; subsequent start runs full sequence from slice_idx=0.
REQ-037 start asserted during VALID -> sequence unaffected, overrun=1 from next cycle and remains 1 until rst.
REQ-038 rst asserted asynchronously between clock edges during VALID -> all outputs 0 before next edge; back-to-back start immediately after DONE -> second latch_ena one cycle after start.
